// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
//   Shared constants and types for the multi-port RISC-V integer register file.
//   XLEN_DEF / NREGS_DEF are the default widths used by rf_riscv_mp and
//   rf_scoreboard; reg_addr_t and xword_t describe a register index and a
//   register word for the default 32 x 32-bit configuration.
// -----------------------------------------------------------------------------
package rf_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);

   typedef logic [AW_DEF-1:0]   reg_addr_t;
   typedef logic [XLEN_DEF-1:0] xword_t;

   // x0 is architecturally hardwired to zero and has no storage.
   localparam reg_addr_t ZERO_REG = '0;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
//   Per-register busy bits for the pipelined core. A register is marked busy
//   when decode issues a producer for it and is released when writeback
//   commits a result to it. x0 is never busy.
//
// Ports
//   clk_i      in   clock, rising edge
//   rst_i      in   synchronous active-high reset, clears every busy bit
//   set        in   reserve register set_addr (issue)
//   set_addr   in   AW      register to reserve
//   clr        in   NWR     per-write-port release request
//   clr_addr   in   NWR*AW  per-write-port register to release
//   busy_vec   out  NREGS   current busy bits, bit 0 tied to 0
// -----------------------------------------------------------------------------
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter  int NREGS = NREGS_DEF,
   parameter  int NWR   = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              set,
   input  logic [AW-1:0]     set_addr,
   input  logic [NWR-1:0]    clr,
   input  logic [NWR*AW-1:0] clr_addr,
   output logic [NREGS-1:0]  busy_vec
);

   // Entry 0 has no storage; walking r from 1 also drops any set or clear
   // aimed at x0 without an explicit address check.
   logic [NREGS-1:1] busy_q;
   logic [NREGS-1:1] busy_d;

   always_comb begin
      // NOTE: every combinational output is given a default before any
      // conditional update so no path leaves it unassigned (no latch).
      busy_d = busy_q;
      for (int r = 1; r < NREGS; r++) begin
         for (int p = 0; p < NWR; p++) begin
            if (clr[p] && (clr_addr[p*AW +: AW] == AW'(r))) begin
               busy_d[r] = 1'b0;
            end
         end
         // Applied after the clears: a newly issued producer outranks the
         // retiring one on the same register.
         if (set && (set_addr == AW'(r))) begin
            busy_d[r] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst_i) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec = {busy_q, 1'b0};

endmodule : rf_scoreboard

// File: rtl/rf_riscv_mp.sv
// -----------------------------------------------------------------------------
// rf_riscv_mp
//   Multi-port integer register file with busy scoreboard. NRD combinational
//   read ports, NWR synchronous write ports (higher port index wins on an
//   address conflict), x0 hardwired to zero.
//
//   Optional feature: define RF_BYPASS_EN for same-cycle write-to-read
//   forwarding of data, with the busy flag of a forwarded register masked
//   unless it is being re-reserved in the same cycle.
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   we_i         in   NWR        per-port write enable
//   waddr_i      in   NWR*AW     per-port write address
//   wdata_i      in   NWR*XLEN   per-port write data
//   raddr_i      in   NRD*AW     per-port read address
//   rdata_o      out  NRD*XLEN   per-port read data (combinational)
//   busy_set_i   in   reserve a destination register
//   busy_addr_i  in   AW         register to reserve
//   rbusy_o      out  NRD        busy flag of raddr_i[k]
//   busy_vec_o   out  NREGS      full scoreboard, bit 0 always 0
// -----------------------------------------------------------------------------
module rf_riscv_mp
   import rf_pkg::*;
#(
   parameter  int XLEN  = XLEN_DEF,
   parameter  int NREGS = NREGS_DEF,
   parameter  int NRD   = 2,
   parameter  int NWR   = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NWR-1:0]      we_i,
   input  logic [NWR*AW-1:0]   waddr_i,
   input  logic [NWR*XLEN-1:0] wdata_i,
   input  logic [NRD*AW-1:0]   raddr_i,
   output logic [NRD*XLEN-1:0] rdata_o,
   input  logic                busy_set_i,
   input  logic [AW-1:0]       busy_addr_i,
   output logic [NRD-1:0]      rbusy_o,
   output logic [NREGS-1:0]    busy_vec_o
);

   logic [XLEN-1:0] regs_q [NREGS-1:1];

   // ---------------------------------------------------------------- storage
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the array is reset explicitly because a cleared file is
         // architecturally visible after reset; this rules out a RAM macro.
         for (int r = 1; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         // Ports are visited in ascending order, so the last matching
         // non-blocking update (highest port) is the one that lands.
         for (int r = 1; r < NREGS; r++) begin
            for (int p = 0; p < NWR; p++) begin
               if (we_i[p] && (waddr_i[p*AW +: AW] == AW'(r))) begin
                  regs_q[r] <= wdata_i[p*XLEN +: XLEN];
               end
            end
         end
      end
   end

   // -------------------------------------------------------------- scoreboard
   rf_scoreboard #(
      .NREGS (NREGS),
      .NWR   (NWR)
   ) u_scoreboard (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .set      (busy_set_i),
      .set_addr (busy_addr_i),
      .clr      (we_i),
      .clr_addr (waddr_i),
      .busy_vec (busy_vec_o)
   );

   // ------------------------------------------------------------------ reads
`ifdef RF_BYPASS_EN
   logic byp_hit;
`endif

   always_comb begin
      rdata_o = '0;
      rbusy_o = '0;
`ifdef RF_BYPASS_EN
      byp_hit = 1'b0;
`endif
      for (int k = 0; k < NRD; k++) begin
         // Address 0 matches no stored entry and therefore reads 0 / not busy.
         for (int r = 1; r < NREGS; r++) begin
            if (raddr_i[k*AW +: AW] == AW'(r)) begin
               rdata_o[k*XLEN +: XLEN] = regs_q[r];
               rbusy_o[k]              = busy_vec_o[r];
            end
         end
`ifdef RF_BYPASS_EN
         byp_hit = 1'b0;
         if (!rst_i && (raddr_i[k*AW +: AW] != AW'(ZERO_REG))) begin
            for (int p = 0; p < NWR; p++) begin
               if (we_i[p] && (waddr_i[p*AW +: AW] == raddr_i[k*AW +: AW])) begin
                  rdata_o[k*XLEN +: XLEN] = wdata_i[p*XLEN +: XLEN];
                  byp_hit                 = 1'b1;
               end
            end
         end
         // The committing write releases the register now, unless decode is
         // reserving it again in this same cycle.
         if (byp_hit && !(busy_set_i && (busy_addr_i == raddr_i[k*AW +: AW]))) begin
            rbusy_o[k] = 1'b0;
         end
`endif
      end
   end

endmodule : rf_riscv_mp

// File: doc/rf_riscv_mp.md
# rf_riscv_mp

Parametrised multi-port integer register file for the RISC-V core. It generalises the single-write, dual-read file to NRD asynchronous read ports and NWR synchronous write ports, and adds a per-register busy scoreboard for the pipelined core. It sits between decode (operand read, busy check, destination reservation) and writeback (result commit). x0 stays hardwired to zero.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: number of architectural registers; power of two, ≥ 2. AW = $clog2(NREGS).
- NRD, 2: number of read ports, 1..4.
- NWR, 2: number of write ports, 1..2. Higher index has priority.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- we_i  in  NWR  per-port write enable.
- waddr_i  in  NWR×AW  per-port write address.
- wdata_i  in  NWR×XLEN  per-port write data.
- raddr_i  in  NRD×AW  per-port read address.
- rdata_o  out  NRD×XLEN  per-port read data, combinational.
- busy_set_i  in  1  reserve a destination register (issue).
- busy_addr_i  in  AW  register to reserve.
- rbusy_o  out  NRD  busy flag of the register addressed by raddr_i[k].
- busy_vec_o  out  NREGS  full scoreboard; bit 0 is always 0.

## Operation
- Storage: NREGS-1 registers of XLEN bits, plus NREGS-1 busy bits. Entry 0 is not stored. Reading x0 returns 0 and busy 0.
- Reset: when rst_i=1 at an edge, every register is cleared to 0 and every busy bit is cleared, whatever the other inputs are. Reset dominates writes and sets.
- Write: when we_i[p]=1 and waddr_i[p]≠0, the register at waddr_i[p] gets wdata_i[p] at the edge. Writes to x0 are dropped silently.
- Write conflict: if two ports target the same address in one cycle, port NWR-1 wins and the other write is lost.
- Busy clear: any accepted write (we_i=1, addr≠0) clears the busy bit for its address.
- Busy set: busy_set_i=1 with busy_addr_i≠0 sets the busy bit for that address. A set to x0 is ignored.
- Set and clear on the same register in one cycle: set wins, because a new producer has been issued.
- Reads: rdata_o[k] and rbusy_o[k] depend only on raddr_i[k] and the stored state, plus the bypass path when RF_BYPASS_EN is defined. Read ports are fully independent and the same address may appear on several ports.
- Outputs after reset: rdata_o = 0 for every address, rbusy_o = 0, busy_vec_o = 0.

## Timing
- Read latency: 0 cycles (combinational).
- Write latency without bypass: data is visible on rdata_o in the cycle after the write edge.
- Busy set latency: the flag is visible in the cycle after busy_set_i.
- Busy clear latency: 1 cycle, or 0 with bypass (see Configuration).
- No handshake: every write and set is accepted in the cycle it is presented; there is no backpressure.
- Reset asserted mid-stream: any write or set in the same cycle is discarded. State is clean from the following cycle.

## Configuration
- RF_BYPASS_EN defined: same-cycle write-to-read forwarding.
  - If we_i[p]=1 and waddr_i[p]=raddr_i[k]≠0, rdata_o[k] = wdata_i[p], choosing the highest-index matching port.
  - rbusy_o[k] is forced to 0 for that address unless busy_set_i targets the same address in that cycle.
  - Forwarding is suppressed while rst_i=1.
- RF_BYPASS_EN undefined: no forwarding. Reads return stored state only, and the 1-cycle latencies above apply.

## Structure
- Package rf_pkg holds:
  - default constants XLEN_DEF and NREGS_DEF;
  - typedef reg_addr_t (logic [AW-1:0]) for NREGS=32;
  - typedef xword_t (logic [XLEN-1:0]);
  - constant ZERO_REG = 0.
- One sub-module, rf_scoreboard, holds the busy bits.
  - It takes the set request and the NWR clear requests plus rst_i.
  - It outputs busy_vec_o.
  - Read-side rbusy_o indexing and bypass masking stay in the top level.

## Test plan
- Reset: preload x5=0xDEADBEEF and reserve x5 busy, then pulse rst_i for 1 cycle → next cycle rdata(x5)=0 and busy_vec_o=0.
- x0 guard: write 0x12345678 to x0 on both ports and busy_set to x0 → rdata(x0)=0 and rbusy=0, on all read ports.
- Write conflict: port0 writes x7=0x1111 and port1 writes x7=0x2222 in the same cycle → x7 reads 0x2222 next cycle.
- Scoreboard:
  - set x3 → rbusy=1 next cycle;
  - write x3=0xA5 → busy clears next cycle;
  - same-cycle set x4 and write x4 → x4 remains busy and holds the new data.
- Bypass: write x9=0xCAFE while raddr=x9.
  - With RF_BYPASS_EN defined: rdata=0xCAFE in the same cycle.
  - Without it: the old value in that cycle, 0xCAFE the next cycle.
- Reset plus write: rst_i=1 with we_i[0]=1 on x2=0x55 → x2 reads 0 afterwards.
